dcache_port_arbiter: RTL

// - Responder side of the two memory-stage data ports: merges the sram-like data requests of pipe path 1
//   (older slot) and path 2 into the single dcache port, then routes each dcache_data_ok/rdata back to its issuer.
// - Sits between the two mem stages and the dcache. Tracks outstanding requests in order and discards

---
 rtl/dcache_port_arbiter_pkg.sv | 25 ++
 rtl/dcache_req_fifo.sv | 62 ++++++
 rtl/dcache_port_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared encodings and the request-tracking entry for the two-port dcache arbiter.
package dcache_port_arbiter_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic PORT_P1 = 1'b0;
   localparam logic PORT_P2 = 1'b1;

   typedef struct packed {
      logic id;
      logic wr;
      logic discard;
   } req_entry_t;

   function automatic req_entry_t make_entry(input logic id, input logic wr);
      req_entry_t e;
      e.id      = id;
      e.wr      = wr;
      e.discard = 1'b0;
      return e;
   endfunction

endpackage

// File: rtl/dcache_req_fifo.sv
// In-order tracker of outstanding dcache transactions; flush marks every live entry as orphaned.
module dcache_req_fifo
   import dcache_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  req_entry_t       push_entry,
   input  logic             pop,
   input  logic             flush_mark,
   output req_entry_t       head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic             id_q      [DEPTH];
   logic             wr_q      [DEPTH];
   logic             discard_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   assign head.id      = id_q[rd_ptr];
   assign head.wr      = wr_q[rd_ptr];
   assign head.discard = discard_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Stale slots may be marked by flush; a push always rewrites its slot clean.
   always_ff @(posedge clk) begin
      if (flush_mark) begin
         for (int i = 0; i < DEPTH; i++) discard_q[i] <= 1'b1;
      end
      if (push_ok) begin
         id_q[wr_ptr]      <= push_entry.id;
         wr_q[wr_ptr]      <= push_entry.wr;
         discard_q[wr_ptr] <= push_entry.discard;
      end
   end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Merges the two mem-stage sram-like ports onto one dcache port and routes responses back in order.
module dcache_port_arbiter
   import dcache_port_arbiter_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,

   input  logic                p1_req,
   input  logic                p1_wr,
   input  logic [1:0]          p1_size,
   input  logic [DATA_W/8-1:0] p1_wstrb,
   input  logic [ADDR_W-1:0]   p1_addr,
   input  logic [DATA_W-1:0]   p1_wdata,
   output logic                p1_addr_ok,
   output logic                p1_data_ok,
   output logic [DATA_W-1:0]   p1_rdata,

   input  logic                p2_req,
   input  logic                p2_wr,
   input  logic [1:0]          p2_size,
   input  logic [DATA_W/8-1:0] p2_wstrb,
   input  logic [ADDR_W-1:0]   p2_addr,
   input  logic [DATA_W-1:0]   p2_wdata,
   output logic                p2_addr_ok,
   output logic                p2_data_ok,
   output logic [DATA_W-1:0]   p2_rdata,

   output logic                dc_req,
   output logic                dc_wr,
   output logic [1:0]          dc_size,
   output logic [DATA_W/8-1:0] dc_wstrb,
   output logic [ADDR_W-1:0]   dc_addr,
   output logic [DATA_W-1:0]   dc_wdata,
   input  logic                dc_addr_ok,
   input  logic                dc_data_ok,
   input  logic [DATA_W-1:0]   dc_rdata,

   output logic                busy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             gnt1;
   logic             gnt2;
   logic             push;
   logic             pop;
   logic             resp_ok;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   req_entry_t       head;
   req_entry_t       push_entry;
   logic             unused_head_wr;

   assign gnt1 = p1_req;
   assign gnt2 = p2_req & ~p1_req;

   assign dc_req   = (p1_req | p2_req) & ~full & ~flush & ~reset;
   assign dc_wr    = gnt1 ? p1_wr    : p2_wr;
   assign dc_size  = gnt1 ? p1_size  : p2_size;
   assign dc_wstrb = gnt1 ? p1_wstrb : p2_wstrb;
   assign dc_addr  = gnt1 ? p1_addr  : p2_addr;
   assign dc_wdata = gnt1 ? p1_wdata : p2_wdata;

   assign push       = dc_req & dc_addr_ok;
   assign p1_addr_ok = gnt1 & push;
   assign p2_addr_ok = gnt2 & push;
   assign push_entry = make_entry(gnt1 ? PORT_P1 : PORT_P2, dc_wr);

   // A response with nothing outstanding is a dcache protocol error and is dropped.
   assign pop     = dc_data_ok & ~empty & ~reset;
   assign resp_ok = pop & ~head.discard & ~flush;

   assign p1_data_ok = resp_ok & (head.id == PORT_P1);
   assign p2_data_ok = resp_ok & (head.id == PORT_P2);
   assign p1_rdata   = dc_rdata;
   assign p2_rdata   = dc_rdata;

   assign busy = (count != '0);

   // Store/load flag is tracked per entry for debug visibility only.
   assign unused_head_wr = head.wr;

   dcache_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush_mark (flush),
      .head       (head),
      .full       (full),
      .empty      (empty),
      .count      (count)
   );

endmodule
